// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared defaults and state encoding for the NoC FIFO write
//                arbiter. Holds the requester count, flit width, flit
//                counter width and the two-state lock FSM encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package noc_pkg;

    // Default number of requesters sharing the FIFO write port.
    localparam int NOC_N_REQ  = 4;

    // Default flit width, equal to the FIFO slot width.
    localparam int NOC_DATA_W = 64;

    // Width of the running flit counter.
    localparam int NOC_CNT_W  = 16;

    // Lock FSM encoding.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/noc_fifo_wr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Purely combinational round-robin picker. Searches the
//                request vector starting at last_id+1 (mod N_REQ) and returns
//                the first set requester.
//  Ports       : req_i       - request vector, one bit per requester
//                last_id_i   - requester that most recently finished a packet
//                gnt_id_o    - selected requester (0 when none)
//                gnt_valid_o - high when any request was found
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_id_i,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             gnt_valid_o
);

    // One extra bit so last_id + offset never overflows before wrapping.
    localparam logic [ID_W:0] C_N = (ID_W+1)'(N_REQ);

    logic [ID_W:0] w_pos;

    // Walk offsets from farthest to nearest so the nearest hit (the highest
    // round-robin priority) is the final assignment and wins.
    always_comb begin
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        w_pos       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_pos = {1'b0, last_id_i} + (ID_W+1)'(k);
            // last_id < N and k <= N, so one subtraction is enough to wrap.
            if (w_pos >= C_N) begin
                w_pos = w_pos - C_N;
            end
            if (req_i[w_pos[ID_W-1:0]]) begin
                gnt_id_o    = w_pos[ID_W-1:0];
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/noc_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : noc_fifo_wr_arb
//  Description : Packet-aware arbiter sharing one FIFO write port among
//                N_REQ requesters. Round-robin between packets; once a
//                multi-flit packet starts, its owner keeps the port until the
//                flit carrying req_last is written.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                req_valid/data/last - per-requester flit stream
//                req_ready           - per-requester accept
//                fifo_full           - downstream FIFO full flag
//                fifo_write_en/_in   - FIFO write strobe and data
//                grant_id            - current grant (0 when none)
//                locked              - a multi-flit packet owns the port
//                flit_cnt            - flits written since reset (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module noc_fifo_wr_arb
    import noc_pkg::*;
#(
    parameter int N_REQ  = NOC_N_REQ,
    parameter int DATA_W = NOC_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_write_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      locked,
    output logic [NOC_CNT_W-1:0]      flit_cnt
);

    localparam int ID_W = $clog2(N_REQ);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [0:0]           state_q,    state_d;
    logic [ID_W-1:0]      own_id_q,   own_id_d;
    logic [ID_W-1:0]      last_id_q,  last_id_d;
    logic [NOC_CNT_W-1:0] flit_cnt_q, flit_cnt_d;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [ID_W-1:0]   w_rr_id;
    logic              w_rr_valid;
    logic [ID_W-1:0]   w_gnt_id;
    logic              w_gnt_any;
    logic              w_gnt_last;
    logic              w_xfer;
    logic [DATA_W-1:0] w_data_arr [N_REQ];

    // Split the flat data bus into one slot per requester.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req_i       (req_valid),
        .last_id_i   (last_id_q),
        .gnt_id_o    (w_rr_id),
        .gnt_valid_o (w_rr_valid)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            own_id_q   <= '0;
            // Start just "behind" requester 0 so it has first priority.
            last_id_q  <= ID_W'(N_REQ - 1);
            flit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            own_id_q   <= own_id_d;
            last_id_q  <= last_id_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        own_id_d   = own_id_q;
        last_id_d  = last_id_q;
        flit_cnt_d = flit_cnt_q;

        if (w_xfer) begin
            flit_cnt_d = flit_cnt_q + 1'b1;

            case (state_q)
                ST_IDLE: begin
                    // A first flit without last opens a multi-flit packet.
                    if (!w_gnt_last) begin
                        state_d  = ST_LOCKED;
                        own_id_d = w_gnt_id;
                    end
                end
                ST_LOCKED: begin
                    if (w_gnt_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // End of any packet moves the round-robin pointer.
            if (w_gnt_last) begin
                last_id_d = w_gnt_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        // While locked only the owner is eligible, even if it is idle.
        if (state_q == ST_LOCKED) begin
            w_gnt_id  = own_id_q;
            w_gnt_any = 1'b1;
        end else begin
            w_gnt_id  = w_rr_id;
            w_gnt_any = w_rr_valid;
        end

        w_gnt_last = req_last[w_gnt_id];

        req_ready = '0;
        if (!reset && w_gnt_any && !fifo_full) begin
            req_ready[w_gnt_id] = 1'b1;
        end

        // fifo_full gates ready, so no write can happen into a full FIFO.
        w_xfer        = req_valid[w_gnt_id] & req_ready[w_gnt_id];
        fifo_write_en = w_xfer;

        fifo_data_in = '0;
        if (!reset && w_gnt_any) begin
            fifo_data_in = w_data_arr[w_gnt_id];
        end
    end

    assign grant_id = w_gnt_id;
    assign locked   = (state_q == ST_LOCKED);
    assign flit_cnt = flit_cnt_q;

endmodule : noc_fifo_wr_arb
`default_nettype wire

// File: tb/tb_noc_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_fifo_wr_arb
//  Description : Self-checking bench for noc_fifo_wr_arb (N_REQ=4, 64-bit).
//                A behavioural reference model predicts each cycle's outputs;
//                predictions are queued when stimulus is applied and popped
//                when the DUT outputs are sampled mid-cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_noc_fifo_wr_arb;

    localparam int NR = 4;
    localparam int DW = 64;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             fifo_full;
    logic             fifo_write_en;
    logic [DW-1:0]    fifo_data_in;
    logic [1:0]       grant_id;
    logic             locked;
    logic [15:0]      flit_cnt;

    noc_fifo_wr_arb #(
        .N_REQ  (NR),
        .DATA_W (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .fifo_full     (fifo_full),
        .fifo_write_en (fifo_write_en),
        .fifo_data_in  (fifo_data_in),
        .grant_id      (grant_id),
        .locked        (locked),
        .flit_cnt      (flit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [NR-1:0] rdy;
        logic [DW-1:0] data;
        logic [1:0]    gid;
        logic          lk;
        logic [15:0]   cnt;
    } exp_t;

    exp_t sb_q[$];
    int   wr_hist[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_locked;
    int          m_own;
    int          m_last;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_locked = 1'b0;
        m_own    = 0;
        m_last   = NR - 1;
        m_cnt    = 16'h0000;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = {$urandom, $urandom};
        end
    endtask

    // One clock of traffic: predict, queue, sample at the falling edge,
    // compare, then advance the model across the rising edge.
    // Entered and left 1 time unit after a rising edge.
    task automatic step(input string name);
        exp_t e;
        exp_t got;
        int   g;
        bit   any;
        int   idx;
        any = 1'b0;
        g   = 0;
        if (m_locked) begin
            g   = m_own;
            any = 1'b1;
        end else begin
            for (int k = 1; k <= NR; k++) begin
                idx = (m_last + k) % NR;
                if (!any && req_valid[idx]) begin
                    g   = idx;
                    any = 1'b1;
                end
            end
        end
        e.we   = any && req_valid[g] && !fifo_full;
        e.rdy  = (any && !fifo_full) ? NR'(1 << g) : '0;
        e.data = any ? req_data[g*DW +: DW] : '0;
        e.gid  = 2'(g);
        e.lk   = m_locked;
        e.cnt  = m_cnt;
        sb_q.push_back(e);

        #4;
        got = sb_q.pop_front();
        n_cmp++;
        if (fifo_write_en !== got.we) begin
            n_bad++;
            $display("FAIL %s write_en: got %b expected %b @%0t", name, fifo_write_en, got.we, $time);
        end
        n_cmp++;
        if (req_ready !== got.rdy) begin
            n_bad++;
            $display("FAIL %s req_ready: got %b expected %b @%0t", name, req_ready, got.rdy, $time);
        end
        n_cmp++;
        if (fifo_data_in !== got.data) begin
            n_bad++;
            $display("FAIL %s data: got %h expected %h @%0t", name, fifo_data_in, got.data, $time);
        end
        n_cmp++;
        if (grant_id !== got.gid) begin
            n_bad++;
            $display("FAIL %s grant_id: got %0d expected %0d @%0t", name, grant_id, got.gid, $time);
        end
        n_cmp++;
        if (locked !== got.lk) begin
            n_bad++;
            $display("FAIL %s locked: got %b expected %b @%0t", name, locked, got.lk, $time);
        end
        n_cmp++;
        if (flit_cnt !== got.cnt) begin
            n_bad++;
            $display("FAIL %s flit_cnt: got %h expected %h @%0t", name, flit_cnt, got.cnt, $time);
        end
        if (fifo_write_en === 1'b1) begin
            wr_hist.push_back(int'(grant_id));
        end

        @(posedge clk);
        if (e.we) begin
            m_cnt = m_cnt + 16'd1;
            if (req_last[g]) begin
                m_last   = g;
                m_locked = 1'b0;
            end else if (!m_locked) begin
                m_locked = 1'b1;
                m_own    = g;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] l, input logic f);
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        rand_data();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'b1111, 4'b0000, 1'b0);
        @(posedge clk);
        #5;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        n_cmp++;
        if (fifo_write_en !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_write_en: got %b expected 0", fifo_write_en);
        end
        n_cmp++;
        if (fifo_data_in !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h expected 0", fifo_data_in);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_locked: got %b expected 0", locked);
        end
        n_cmp++;
        if (flit_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_flit_cnt: got %h expected 0000", flit_cnt);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        wr_hist.delete();
        drive(4'b1111, 4'b1111, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rand_data();
            step("rr");
        end
        n_cmp++;
        if (wr_hist.size() != 8) begin
            n_bad++;
            $display("FAIL rr_count: got %0d writes expected 8", wr_hist.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (wr_hist[i] != exp_seq[i]) begin
                    n_bad++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", i, wr_hist[i], exp_seq[i]);
                end
            end
        end
        n_cmp++;
        if (flit_cnt !== 16'd8) begin
            n_bad++;
            $display("FAIL rr_flit_cnt: got %0d expected 8", flit_cnt);
        end
    endtask

    // Requester 2 sends a three-flit packet while 0 and 1 also compete.
    task automatic test_locked_packet();
        wr_hist.delete();
        drive(4'b0100, 4'b0000, 1'b0); step("pkt_f1");
        drive(4'b0111, 4'b0000, 1'b0); step("pkt_f2");
        drive(4'b0111, 4'b0100, 1'b0); step("pkt_f3");
        n_cmp++;
        if (wr_hist.size() != 3 || wr_hist[0] != 2 || wr_hist[1] != 2 || wr_hist[2] != 2) begin
            n_bad++;
            $display("FAIL pkt_owner: got %0d writes, expected 3 from requester 2", wr_hist.size());
        end
        drive(4'b1011, 4'b1111, 1'b0); step("pkt_next3");
        n_cmp++;
        if (wr_hist.size() != 4 || wr_hist[3] != 3) begin
            n_bad++;
            $display("FAIL pkt_next: got %0d writes, expected 4th from requester 3", wr_hist.size());
        end
    endtask

    // Full asserted for five cycles mid-packet on requester 1.
    task automatic test_fifo_full();
        drive(4'b0010, 4'b0000, 1'b0); step("full_f1");
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b0000, 1'b1); step("full_hold");
        end
        n_cmp++;
        if (locked !== 1'b1 || grant_id !== 2'd1) begin
            n_bad++;
            $display("FAIL full_hold_owner: got locked=%b id=%0d expected locked=1 id=1", locked, grant_id);
        end
        wr_hist.delete();
        drive(4'b1111, 4'b0000, 1'b0); step("full_f2");
        drive(4'b1111, 4'b0010, 1'b0); step("full_f3");
        n_cmp++;
        if (wr_hist.size() != 2 || wr_hist[0] != 1 || wr_hist[1] != 1) begin
            n_bad++;
            $display("FAIL full_resume: got %0d writes, expected 2 from requester 1", wr_hist.size());
        end
    endtask

    // Owner (requester 2) goes idle for three cycles while others wait.
    task automatic test_owner_stall();
        drive(4'b1111, 4'b0000, 1'b0); step("stall_f1");
        wr_hist.delete();
        for (int i = 0; i < 3; i++) begin
            drive(4'b1011, 4'b0000, 1'b0); step("stall_gap");
        end
        n_cmp++;
        if (wr_hist.size() != 0 || grant_id !== 2'd2) begin
            n_bad++;
            $display("FAIL stall: got %0d writes id=%0d expected 0 writes id=2", wr_hist.size(), grant_id);
        end
        drive(4'b1111, 4'b1111, 1'b0); step("stall_end");
        drive(4'b1111, 4'b1111, 1'b0); step("stall_after");
    endtask

    // Reset while requester 1 owns the port.
    task automatic test_reset_mid_packet();
        drive(4'b0010, 4'b0000, 1'b0); step("rst_f1");
        drive(4'b0010, 4'b0000, 1'b0); step("rst_f2");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if (locked !== 1'b0 || flit_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_mid: got locked=%b cnt=%h expected locked=0 cnt=0000", locked, flit_cnt);
        end
        wr_hist.delete();
        drive(4'b1111, 4'b1111, 1'b0); step("rst_first");
        n_cmp++;
        if (wr_hist.size() != 1 || wr_hist[0] != 0) begin
            n_bad++;
            $display("FAIL rst_first_grant: got %0d writes, expected one from requester 0", wr_hist.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(NR'($urandom), NR'($urandom), ($urandom_range(0, 3) == 0));
            step("random");
        end
    endtask

    // 65536 single-flit writes from reset wrap the counter back to zero.
    task automatic test_wrap();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(4'b1111, 4'b1111, 1'b0);
        repeat (65535) @(posedge clk);
        #1;
        n_cmp++;
        if (flit_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL wrap_pre: got %h expected ffff", flit_cnt);
        end
        m_locked = 1'b0;
        m_cnt    = 16'hFFFF;
        m_last   = (NR - 1 + 65535) % NR;
        step("wrap_last");
        n_cmp++;
        if (flit_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap: got %h expected 0000", flit_cnt);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_round_robin();
        test_locked_packet();
        test_fifo_full();
        test_owner_stall();
        test_reset_mid_packet();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_noc_fifo_wr_arb
`default_nettype wire
